// File: rtl/network_pkg.sv
// Shared network definitions: evaluator state encoding, population size
// default and the population controller's "running" code.
package network_pkg;

  localparam int         NETWORKS_PER_POPULATION_DEF = 16;
  localparam logic [1:0] NET_STATE_RUNNING           = 2'd1;

  typedef enum logic [1:0] {
    EVAL_IDLE  = 2'd0,
    EVAL_SCORE = 2'd1,
    EVAL_RANK  = 2'd2,
    EVAL_DONE  = 2'd3
  } eval_state_e;

  // Bits needed to hold a count of 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/match_counter.sv
// Counts how many bit positions of two equal-width vectors agree.
module match_counter
  import network_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CW    = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] agree;

  assign agree = ~(a_i ^ b_i);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) count_o = count_o + CW'(agree[i]);
  end

endmodule

// File: rtl/fitness_evaluator.sv
// Accumulates per-network match scores while a population runs, then scans
// the score table for the best network.
module fitness_evaluator
  import network_pkg::*;
#(
  parameter int OUTPUT_COUNT            = 1,
  parameter int NETWORKS_PER_POPULATION = NETWORKS_PER_POPULATION_DEF,
  parameter int SCORE_WIDTH             = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              networkState,
  input  logic [3:0]              activeNetwork,
  input  logic                    networkFinished,
  input  logic                    sampleEnable,
  input  logic [OUTPUT_COUNT-1:0] nout,
  input  logic [OUTPUT_COUNT-1:0] target,
  input  logic [3:0]              scoreAddr,
  output logic [SCORE_WIDTH-1:0]  scoreData,
  output logic [3:0]              bestNetwork,
  output logic [SCORE_WIDTH-1:0]  bestScore,
  output logic                    evalDone,
  output logic                    busy
);

  localparam int                     N         = NETWORKS_PER_POPULATION;
  localparam int                     CW        = count_width(OUTPUT_COUNT);
  localparam int                     XW        = ((SCORE_WIDTH > CW) ? SCORE_WIDTH : CW) + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;
  localparam logic [3:0]             LAST_IDX  = 4'(N - 1);

  eval_state_e            state_q, state_d;
  logic [SCORE_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]             prev_q, prev_d;
  logic [3:0]             scan_q, scan_d;
  logic [3:0]             run_idx_q, run_idx_d;
  logic [SCORE_WIDTH-1:0] run_max_q, run_max_d;
  logic [3:0]             best_net_q, best_net_d;
  logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
  logic [SCORE_WIDTH-1:0] rdata_q, rdata_d;
  logic                   done_q, done_d;
  logic                   nf_q;

  logic [SCORE_WIDTH-1:0] tbl_q [N];
  logic                   tbl_clr, tbl_we;
  logic [3:0]             tbl_wa;
  logic [SCORE_WIDTH-1:0] tbl_wd;

  logic [CW-1:0]          match_cnt, contrib;
  logic [XW-1:0]          sum_acc, sum_new;
  logic [SCORE_WIDTH-1:0] acc_plus, contrib_sat, scan_val;
  logic                   running, fin_rise;

  match_counter #(.WIDTH(OUTPUT_COUNT)) u_match (
    .a_i     (nout),
    .b_i     (target),
    .count_o (match_cnt)
  );

  assign running     = (networkState == NET_STATE_RUNNING);
  assign fin_rise    = networkFinished & ~nf_q;
  assign contrib     = sampleEnable ? match_cnt : '0;
  assign sum_acc     = XW'(acc_q) + XW'(contrib);
  assign sum_new     = XW'(contrib);
  assign acc_plus    = (sum_acc > XW'(SCORE_MAX)) ? SCORE_MAX : sum_acc[SCORE_WIDTH-1:0];
  assign contrib_sat = (sum_new > XW'(SCORE_MAX)) ? SCORE_MAX : sum_new[SCORE_WIDTH-1:0];

  // Table reads are decoded muxes so out-of-range addresses fall through to 0.
  always_comb begin
    scan_val = '0;
    rdata_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (scan_q == 4'(i))    scan_val = tbl_q[i];
      if (scoreAddr == 4'(i)) rdata_d  = tbl_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    prev_d       = prev_q;
    scan_d       = scan_q;
    run_idx_d    = run_idx_q;
    run_max_d    = run_max_q;
    best_net_d   = best_net_q;
    best_score_d = best_score_q;
    done_d       = 1'b0;
    tbl_clr      = 1'b0;
    tbl_we       = 1'b0;
    tbl_wa       = prev_q;
    tbl_wd       = acc_plus;
    unique case (state_q)
      EVAL_IDLE: begin
        if (running) begin
          state_d = EVAL_SCORE;
          acc_d   = '0;
          prev_d  = activeNetwork;
          tbl_clr = 1'b1;
        end
      end
      EVAL_SCORE: begin
        if (!running) begin
          state_d = EVAL_IDLE;
        end else if (fin_rise) begin
          tbl_we  = 1'b1;
          tbl_wd  = acc_plus;
          scan_d  = '0;
          state_d = EVAL_RANK;
        end else if (activeNetwork != prev_q) begin
          // Close out the previous network; this cycle already belongs to the new one.
          tbl_we = 1'b1;
          tbl_wd = acc_q;
          acc_d  = contrib_sat;
          prev_d = activeNetwork;
        end else begin
          acc_d = acc_plus;
        end
      end
      EVAL_RANK: begin
        if (!running) begin
          state_d = EVAL_IDLE;
        end else begin
          // Strictly-greater compare keeps the lower index on ties.
          if (scan_q == 4'd0 || scan_val > run_max_q) begin
            run_max_d = scan_val;
            run_idx_d = scan_q;
          end
          if (scan_q == LAST_IDX) begin
            best_net_d   = run_idx_d;
            best_score_d = run_max_d;
            done_d       = 1'b1;
            state_d      = EVAL_DONE;
          end else begin
            scan_d = scan_q + 4'd1;
          end
        end
      end
      EVAL_DONE: begin
        if (!running) state_d = EVAL_IDLE;
      end
      default: state_d = EVAL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EVAL_IDLE;
      acc_q        <= '0;
      prev_q       <= '0;
      scan_q       <= '0;
      run_idx_q    <= '0;
      run_max_q    <= '0;
      best_net_q   <= '0;
      best_score_q <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      nf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      prev_q       <= prev_d;
      scan_q       <= scan_d;
      run_idx_q    <= run_idx_d;
      run_max_q    <= run_max_d;
      best_net_q   <= best_net_d;
      best_score_q <= best_score_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      nf_q         <= networkFinished;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (tbl_clr)                          tbl_q[i] <= '0;
        else if (tbl_we && tbl_wa == 4'(i))   tbl_q[i] <= tbl_wd;
      end
    end
  end

  assign scoreData   = rdata_q;
  assign bestNetwork = best_net_q;
  assign bestScore   = best_score_q;
  assign evalDone    = done_q;
  assign busy        = (state_q == EVAL_SCORE) || (state_q == EVAL_RANK);

endmodule
